mul_arbiter: RTL and testbench

- Shares one iterative Multiplier instance among NREQ independent requesters (e.g. integer pipe, address-gen, divide-assist).
- Each request is granted round-robin, operands are latched and issued to the multiplier, and the owner tag is tracked.
- The result is returned only to the owner.
- Only one operation is in flight at a time, because the multiplier is not pipelined.

---
 rtl/mul_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/mul_arbiter.sv | 145 ++++++++++++++
 tb/tb_mul_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the multiplier arbiter
//
// Purpose : FSM state type, operand slice offset helper and owner-index
//           width helper shared by mul_arbiter and its sub-modules.
// Ports   : none (package).
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mulState_t;

    localparam int MUL_DEF_NREQ = 4;

    // Bit offset of requester idx inside a packed operand bus whose slots
    // are width+1 bits wide (operand plus sign/extension bit).
    function automatic int opOffset(input int idx, input int width);
        return idx * (width + 1);
    endfunction

    // Owner index width; never below one bit so a vector can always be declared.
    function automatic int mulOwnerW(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

    localparam int MUL_OWNER_W = mulOwnerW(MUL_DEF_NREQ);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant
//
// Purpose : Picks the first asserted request searching circularly from
//           ptr+1, so the requester at ptr has lowest priority.
// Ports   : req      in  N      request vector
//           ptr      in  IDX_W  last served index
//           grant    out N      one-hot grant (zero when no request)
//           grantIdx out IDX_W  index of the granted requester
//           anyGrant out 1      some request is granted
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grantIdx,
    output logic             anyGrant
);

    int idx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        idx      = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!anyGrant && req[idx]) begin
                anyGrant   = 1'b1;
                grant[idx] = 1'b1;
                grantIdx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sharing of one iterative multiplier
//
// Purpose : Grants one of NREQ requesters, latches its operands, issues them
//           to a non-pipelined multiplier, captures the result and returns
//           it to the owner only. One operation in flight at a time.
// Ports   : clk, nRst                  clock, sync active-low reset
//           iReqValid/oReqReady        per-requester request handshake
//           iReqMulc/iReqMulr          packed operands, WIDTH+1 bits per slot
//           oRspValid/iRspReady        one-hot response handshake to owner
//           oRspRslt                   shared {hi,lo} result
//           oMulValid/iMulReady        operand issue handshake
//           oMulc/oMulr                issued operands
//           iMulRsltValid/oMulRsltReady result handshake from multiplier
//           iMulRsltHi/iMulRsltLo      result halves
//           oBusy, oOwner              status / debug
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic [NREQ-1:0]              iReqValid,
    output logic [NREQ-1:0]              oReqReady,
    input  logic [NREQ*(WIDTH+1)-1:0]    iReqMulc,
    input  logic [NREQ*(WIDTH+1)-1:0]    iReqMulr,
    output logic [NREQ-1:0]              oRspValid,
    input  logic [NREQ-1:0]              iRspReady,
    output logic [2*WIDTH-1:0]           oRspRslt,
    output logic                         oMulValid,
    input  logic                         iMulReady,
    output logic [WIDTH:0]               oMulc,
    output logic [WIDTH:0]               oMulr,
    input  logic                         iMulRsltValid,
    output logic                         oMulRsltReady,
    input  logic [WIDTH-1:0]             iMulRsltHi,
    input  logic [WIDTH-1:0]             iMulRsltLo,
    output logic                         oBusy,
    output logic [mulOwnerW(NREQ)-1:0]   oOwner
);

    localparam int OWNER_W = mulOwnerW(NREQ);

    mulState_t            state;
    mulState_t            nextState;
    logic [OWNER_W-1:0]   rrPtr;
    logic [OWNER_W-1:0]   owner;
    logic [WIDTH:0]       mulcReg;
    logic [WIDTH:0]       mulrReg;
    logic [2*WIDTH-1:0]   rsltReg;

    logic [NREQ-1:0]      grantVec;
    logic [OWNER_W-1:0]   grantIdx;
    logic                 anyGrant;
    logic                 reqFire;
    logic                 rsltFire;
    logic [WIDTH:0]       selMulc;
    logic [WIDTH:0]       selMulr;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (OWNER_W)
    ) uRrArbiter (
        .req      (iReqValid),
        .ptr      (rrPtr),
        .grant    (grantVec),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    assign selMulc = iReqMulc[opOffset(int'(grantIdx), WIDTH) +: WIDTH+1];
    assign selMulr = iReqMulr[opOffset(int'(grantIdx), WIDTH) +: WIDTH+1];

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state   <= IDLE;
            rrPtr   <= OWNER_W'(NREQ - 1);
            owner   <= '0;
            mulcReg <= '0;
            mulrReg <= '0;
            rsltReg <= '0;
        end else begin
            state <= nextState;
            if (reqFire) begin
                mulcReg <= selMulc;
                mulrReg <= selMulr;
                owner   <= grantIdx;
                rrPtr   <= grantIdx;
            end
            if (rsltFire) begin
                rsltReg <= {iMulRsltHi, iMulRsltLo};
            end
        end
    end

    always_comb begin
        nextState     = state;
        oReqReady     = '0;
        oRspValid     = '0;
        oMulValid     = 1'b0;
        oMulRsltReady = 1'b0;
        reqFire       = 1'b0;
        rsltFire      = 1'b0;
        case (state)
            IDLE: begin
                // Gated by nRst so no grant is offered while reset is held.
                if (nRst) begin
                    oReqReady = grantVec;
                    reqFire   = anyGrant;
                end
                if (reqFire) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                oMulValid = 1'b1;
                if (iMulReady) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                oMulRsltReady = 1'b1;
                if (iMulRsltValid) begin
                    rsltFire  = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                oRspValid = NREQ'(1) << owner;
                if (iRspReady[owner]) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign oMulc    = mulcReg;
    assign oMulr    = mulrReg;
    assign oRspRslt = rsltReg;
    assign oBusy    = (state != IDLE);
    assign oOwner   = owner;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter
module tb_mul_arbiter;

    localparam int W        = 8;
    localparam int N        = 4;
    localparam int STUB_LAT = 4;
    // Handshake edge -> issue accepted next edge -> STUB_LAT edges -> capture edge.
    localparam int EXP_LAT  = 2 + STUB_LAT;

    logic                 clk = 1'b0;
    logic                 nRst;
    logic [N-1:0]         iReqValid;
    logic [N-1:0]         oReqReady;
    logic [N*(W+1)-1:0]   iReqMulc;
    logic [N*(W+1)-1:0]   iReqMulr;
    logic [N-1:0]         oRspValid;
    logic [N-1:0]         iRspReady;
    logic [2*W-1:0]       oRspRslt;
    logic                 oMulValid;
    logic                 iMulReady;
    logic [W:0]           oMulc;
    logic [W:0]           oMulr;
    logic                 iMulRsltValid;
    logic                 oMulRsltReady;
    logic [W-1:0]         iMulRsltHi;
    logic [W-1:0]         iMulRsltLo;
    logic                 oBusy;
    logic [1:0]           oOwner;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk           (clk),
        .nRst          (nRst),
        .iReqValid     (iReqValid),
        .oReqReady     (oReqReady),
        .iReqMulc      (iReqMulc),
        .iReqMulr      (iReqMulr),
        .oRspValid     (oRspValid),
        .iRspReady     (iRspReady),
        .oRspRslt      (oRspRslt),
        .oMulValid     (oMulValid),
        .iMulReady     (iMulReady),
        .oMulc         (oMulc),
        .oMulr         (oMulr),
        .iMulRsltValid (iMulRsltValid),
        .oMulRsltReady (oMulRsltReady),
        .iMulRsltHi    (iMulRsltHi),
        .iMulRsltLo    (iMulRsltLo),
        .oBusy         (oBusy),
        .oOwner        (oOwner)
    );

    function automatic logic [15:0] prod16(input logic [8:0] a, input logic [8:0] b);
        logic signed [17:0] p;
        p = $signed(a) * $signed(b);
        return p[15:0];
    endfunction

    // Multiplier stub: STUB_LAT cycles after accepting operands it raises
    // result valid and holds it until taken. Result bus carries junk otherwise.
    logic        mulReadyEn;
    logic        stubBusy;
    int          stubCnt;
    logic [15:0] stubProd;

    assign iMulReady = mulReadyEn;
    assign {iMulRsltHi, iMulRsltLo} = iMulRsltValid ? stubProd : 16'hDEAD;

    always @(posedge clk) begin
        if (!nRst) begin
            stubBusy      <= 1'b0;
            stubCnt       <= 0;
            stubProd      <= '0;
            iMulRsltValid <= 1'b0;
        end else if (!stubBusy) begin
            if (oMulValid && iMulReady) begin
                stubBusy <= 1'b1;
                stubCnt  <= STUB_LAT - 1;
                stubProd <= prod16(oMulc, oMulr);
            end
        end else if (!iMulRsltValid) begin
            if (stubCnt == 0) iMulRsltValid <= 1'b1;
            else              stubCnt <= stubCnt - 1;
        end else if (oMulRsltReady) begin
            iMulRsltValid <= 1'b0;
            stubBusy      <= 1'b0;
        end
    end

    int nTests = 0;
    int nFail  = 0;
    int lastServed;
    int lastLat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference grant: first valid requester after the last one served.
    function automatic int modelGrant(input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            if (v[(lastServed + off) % N]) return (lastServed + off) % N;
        end
        return -1;
    endfunction

    task automatic setOps(input int i, input logic [8:0] c, input logic [8:0] r);
        iReqMulc[i*(W+1) +: W+1] = c;
        iReqMulr[i*(W+1) +: W+1] = r;
    endtask

    // One full transaction from IDLE. Caller sets iReqValid/operands at +1
    // after an edge; this checks grant, issue, response and consumption.
    task automatic runTxn(input int rspDelay, input int stall, input bit keep, output int g);
        int          e;
        int          cyc;
        logic [8:0]  c;
        logic [8:0]  r;
        logic [15:0] expRes;
        #1;
        e = modelGrant(iReqValid);
        g = e;
        if (e < 0) begin
            chk("model_has_request", 0, 1);
            return;
        end
        chk("grant_onehot", oReqReady, 32'(1) << e);
        chk("idle_not_busy", oBusy, 0);
        c = iReqMulc[e*(W+1) +: W+1];
        r = iReqMulr[e*(W+1) +: W+1];
        expRes = prod16(c, r);
        if (stall > 0) mulReadyEn = 1'b0;
        tick();
        lastServed = e;
        if (!keep) iReqValid[e] = 1'b0;
        // New operands after the handshake must not disturb the issued ones.
        setOps(e, 9'($urandom), 9'($urandom));
        #1;
        chk("issue_valid", oMulValid, 1);
        chk("issue_mulc", oMulc, c);
        chk("issue_mulr", oMulr, r);
        chk("owner", oOwner, e);
        chk("no_grant_busy", oReqReady, 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", oMulValid, 1);
            chk("stall_mulc", oMulc, c);
            chk("stall_mulr", oMulr, r);
        end
        mulReadyEn = 1'b1;
        cyc = stall;
        while (oRspValid == '0 && cyc < 60) begin
            tick();
            cyc++;
        end
        lastLat = cyc;
        if (cyc >= 60) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("rsp_onehot", oRspValid, 32'(1) << e);
        chk("rsp_rslt", oRspRslt, expRes);
        for (int d = 0; d < rspDelay; d++) begin
            iRspReady = ~(4'(1) << e);
            tick();
            chk("bp_valid", oRspValid, 32'(1) << e);
            chk("bp_rslt", oRspRslt, expRes);
            chk("bp_no_grant", oReqReady, 0);
        end
        iRspReady = 4'(1) << e;
        tick();
        iRspReady = '0;
        #1;
        chk("rsp_consumed", oRspValid, 0);
    endtask

    int g;
    int expOrder [5] = '{0, 1, 2, 3, 0};

    initial begin
        nRst       = 1'b0;
        iReqValid  = '0;
        iRspReady  = '0;
        iReqMulc   = '0;
        iReqMulr   = '0;
        mulReadyEn = 1'b1;
        lastServed = N - 1;
        tick();
        tick();
        chk("rst_reqready", oReqReady, 0);
        chk("rst_rspvalid", oRspValid, 0);
        chk("rst_mulvalid", oMulValid, 0);
        chk("rst_rsltready", oMulRsltReady, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_rslt", oRspRslt, 0);
        nRst = 1'b1;
        tick();

        // Single request from requester 1.
        setOps(1, 9'h003, 9'h005);
        iReqValid = 4'b0010;
        runTxn(0, 0, 1'b0, g);
        chk("single_latency", lastLat, EXP_LAT);

        // Signed operands, owner 0 only.
        setOps(0, 9'h1FF, 9'h002);
        iReqValid = 4'b0001;
        runTxn(1, 0, 1'b0, g);

        // Contention from reset: all valid, requester 2 backpressured 5 cycles.
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        lastServed = N - 1;
        for (int i = 0; i < N; i++) setOps(i, 9'($urandom), 9'($urandom));
        iReqValid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            runTxn((k == 2) ? 5 : 0, 0, 1'b1, g);
            chk("contention_order", g, expOrder[k]);
        end
        iReqValid = '0;

        // Multiplier stall in ISSUE.
        setOps(3, 9'h07F, 9'h181);
        iReqValid = 4'b1000;
        runTxn(0, 3, 1'b0, g);

        // Reset in the middle of WAIT.
        setOps(1, 9'h011, 9'h013);
        iReqValid = 4'b0010;
        #1;
        tick();
        iReqValid = '0;
        for (int t = 0; t < 20 && !oMulRsltReady; t++) tick();
        chk("reached_wait", oMulRsltReady, 1);
        nRst = 1'b0;
        iReqValid = 4'b0101;
        setOps(0, 9'h004, 9'h004);
        setOps(2, 9'h006, 9'h006);
        #1;
        chk("rst_gate_reqready", oReqReady, 0);
        tick();
        nRst = 1'b1;
        lastServed = N - 1;
        #1;
        chk("midrst_busy", oBusy, 0);
        chk("midrst_mulvalid", oMulValid, 0);
        chk("midrst_rsltready", oMulRsltReady, 0);
        chk("midrst_rspvalid", oRspValid, 0);
        chk("midrst_owner", oOwner, 0);
        chk("midrst_rslt", oRspRslt, 0);
        runTxn(0, 0, 1'b0, g);
        chk("midrst_first_grant", g, 0);
        iReqValid = '0;

        // Randomized phase: changing request sets, random stalls/backpressure.
        for (int k = 0; k < 25; k++) begin
            iReqValid = 4'($urandom_range(1, 15));
            runTxn($urandom_range(0, 3), $urandom_range(0, 2), 1'b1, g);
        end
        iReqValid = '0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
